// File: rtl/interface_wheel_quad_fd.sv
// Multi-channel x4 quadrature wheel-encoder counter with windowed snapshots.
// Each channel synchronizes A/B, decodes steps and reports |cw-ccw| and direction.
module interface_wheel_quad_fd #(
    parameter int N           = 8,
    parameter int CH          = 2,
    parameter int WINDOW      = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [CH-1:0]   A,
    input  logic [CH-1:0]   B,
    input  logic            registra,
    output logic [CH*N-1:0] count,
    output logic [CH-1:0]   CW,
    output logic [CH-1:0]   CCW,
    output logic            valid,
    output logic [CH-1:0]   erro,
    output logic [CH-1:0]   ovf
);

    // state    | meaning
    // INICIAL  | synchronizer/prev pipeline filling, nothing counted
    // CONTA    | counting steps and timing the window
    // REGISTRA | snapshot visible, valid high, counters restart
    typedef enum logic [1:0] {INICIAL, CONTA, REGISTRA} state_t;

    localparam int TW = $clog2(WINDOW);
    localparam int IW = $clog2(SYNC_STAGES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(WINDOW - 1);
    localparam logic [IW-1:0] I_LAST = IW'(SYNC_STAGES);
    localparam logic [N-1:0]  SAT    = '1;

    state_t          state;
    logic [IW-1:0]   init_cnt;
    logic [TW-1:0]   timer;
    logic [CH-1:0]   sync_a [SYNC_STAGES];
    logic [CH-1:0]   sync_b [SYNC_STAGES];
    logic [CH-1:0]   prev_a;
    logic [CH-1:0]   prev_b;
    logic [N-1:0]    cw_cnt  [CH];
    logic [N-1:0]    ccw_cnt [CH];
    logic [N-1:0]    cw_upd  [CH];
    logic [N-1:0]    ccw_upd [CH];
    logic [N-1:0]    snap    [CH];
    logic [CH-1:0]   step_cw;
    logic [CH-1:0]   step_ccw;
    logic [CH-1:0]   illegal;
    logic [CH-1:0]   snap_ccw;
    logic [CH-1:0]   snap_sat;
    logic            run;
    logic            dec_en;
    logic            trigger;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_a[s] <= '0;
                sync_b[s] <= '0;
            end
            prev_a <= '0;
            prev_b <= '0;
        end else begin
            sync_a[0] <= A;
            sync_b[0] <= B;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_a[s] <= sync_a[s-1];
                sync_b[s] <= sync_b[s-1];
            end
            prev_a <= sync_a[SYNC_STAGES-1];
            prev_b <= sync_b[SYNC_STAGES-1];
        end
    end

    // {prev A, prev B, cur A, cur B}: Gray sequence 00->10->11->01 is clockwise
    always_comb begin
        logic [3:0] pc;
        pc       = '0;
        step_cw  = '0;
        step_ccw = '0;
        illegal  = '0;
        for (int i = 0; i < CH; i++) begin
            pc = {prev_a[i], prev_b[i], sync_a[SYNC_STAGES-1][i], sync_b[SYNC_STAGES-1][i]};
            case (pc)
                4'b0010, 4'b1011, 4'b1101, 4'b0100: step_cw[i]  = 1'b1;
                4'b1000, 4'b1110, 4'b0111, 4'b0001: step_ccw[i] = 1'b1;
                4'b0011, 4'b1100, 4'b1001, 4'b0110: illegal[i]  = 1'b1;
                default: ;
            endcase
        end
    end

    assign run     = (state == CONTA) && enable;
    assign dec_en  = enable && (state != INICIAL);
    assign trigger = (state == CONTA) && ((enable && (timer == T_LAST)) || registra);

    // Snapshot uses the counter values including a step decoded in the trigger cycle
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cw_upd[i]  = (run && step_cw[i]  && (cw_cnt[i]  != SAT)) ? cw_cnt[i]  + N'(1) : cw_cnt[i];
            ccw_upd[i] = (run && step_ccw[i] && (ccw_cnt[i] != SAT)) ? ccw_cnt[i] + N'(1) : ccw_cnt[i];
            snap_ccw[i] = cw_upd[i] < ccw_upd[i];
            snap[i]     = snap_ccw[i] ? ccw_upd[i] - cw_upd[i] : cw_upd[i] - ccw_upd[i];
            snap_sat[i] = (cw_upd[i] == SAT) || (ccw_upd[i] == SAT);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= INICIAL;
            init_cnt <= '0;
            timer    <= '0;
            count    <= '0;
            CW       <= '0;
            CCW      <= '0;
            valid    <= 1'b0;
            erro     <= '0;
            ovf      <= '0;
            for (int i = 0; i < CH; i++) begin
                cw_cnt[i]  <= '0;
                ccw_cnt[i] <= '0;
            end
        end else begin
            valid <= 1'b0;
            erro  <= erro | (illegal & {CH{dec_en}});
            case (state)
                INICIAL: begin
                    timer <= '0;
                    for (int i = 0; i < CH; i++) begin
                        cw_cnt[i]  <= '0;
                        ccw_cnt[i] <= '0;
                    end
                    if (init_cnt == I_LAST) begin
                        state <= CONTA;
                    end else begin
                        init_cnt <= init_cnt + IW'(1);
                    end
                end
                CONTA: begin
                    if (enable) begin
                        timer <= timer + TW'(1);
                    end
                    for (int i = 0; i < CH; i++) begin
                        cw_cnt[i]  <= cw_upd[i];
                        ccw_cnt[i] <= ccw_upd[i];
                    end
                    if (trigger) begin
                        state <= REGISTRA;
                        valid <= 1'b1;
                        for (int i = 0; i < CH; i++) begin
                            count[i*N +: N] <= snap[i];
                            CCW[i]          <= snap_ccw[i];
                            CW[i]           <= ~snap_ccw[i];
                            ovf[i]          <= snap_sat[i];
                        end
                    end
                end
                REGISTRA: begin
                    // This cycle is the first of the new window
                    timer <= TW'(enable);
                    for (int i = 0; i < CH; i++) begin
                        cw_cnt[i]  <= N'(enable & step_cw[i]);
                        ccw_cnt[i] <= N'(enable & step_ccw[i]);
                    end
                    state <= CONTA;
                end
                default: state <= INICIAL;
            endcase
        end
    end

endmodule
